regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined CPU datapath. It provides NUM_RD combinational read ports and two clocked write ports (ALU/writeback and load/secondary retire). A per-register busy scoreboard lets decode stall on pending producers. Register 0 is hardwired to zero. An optional same-cycle write-to-read bypass removes the need for external forwarding muxes.

---
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Register file for the pipelined CPU datapath. It has NUM_RD combinational
// read ports, two clocked write ports and a per-register busy scoreboard.
// Register 0 always reads as zero and is never busy.
//
// Optional feature macro:
//   REGFILE_BYPASS_EN - when defined, a write happening this cycle is forwarded
//                       to any read port that addresses the same register, and
//                       that port's busy flag reads 0. Port 1 takes priority
//                       over port 0. When the macro is undefined, reads come
//                       only from stored state and no address comparators are
//                       built.
//
// Parameters:
//   DATA_W  register width in bits
//   ADDR_W  address width; depth = 2**ADDR_W
//   NUM_RD  number of read ports (1..4)
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-high; clears all data and busy bits
//   rd_addr        read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data        read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy        port k's addressed register has a pending producer
//   wr0_en/addr/data  write port 0
//   wr1_en/addr/data  write port 1; it wins over port 0 on an address collision
//   busy_set_en    mark busy_set_addr pending (instruction issue)
//   busy_set_addr  register to mark pending
//   busy_vec       full scoreboard; bit 0 is always 0
//
// Interface semantics: there is no handshake and no back-pressure. Every
// enabled write and busy_set completes at the edge of the cycle in which it
// is presented. The scoreboard is exposed through busy_vec for observation.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       busy_set_en,
  input  logic [ADDR_W-1:0]          busy_set_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Writes and busy sets aimed at register 0 are discarded here, so the rest
  // of the logic never has to special-case address 0 on the write side.
  logic wr0_act;
  logic wr1_act;
  logic set_act;

  assign wr0_act = wr0_en && (wr0_addr != '0);
  assign wr1_act = wr1_en && (wr1_addr != '0);
  assign set_act = busy_set_en && (busy_set_addr != '0);

  // Retiring writes clear their busy bit; a new issue to the same register in
  // the same cycle is applied last so the newer producer keeps it pending.
  always_comb begin
    busy_d = busy_q;
    if (wr0_act) busy_d[wr0_addr] = 1'b0;
    if (wr1_act) busy_d[wr1_addr] = 1'b0;
    if (set_act) busy_d[busy_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr0_act) regs_q[wr0_addr] <= wr0_data;
      // Port 1 is written after port 0 so it wins on a collision.
      if (wr1_act) regs_q[wr1_addr] <= wr1_data;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              addr_nz;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign addr_nz = (addr != '0);

`ifdef REGFILE_BYPASS_EN
    logic hit0;
    logic hit1;

    // wrN_act already excludes address 0, so a hit implies addr_nz.
    assign hit0 = wr0_act && (wr0_addr == addr);
    assign hit1 = wr1_act && (wr1_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] = !addr_nz ? '0       :
                                         hit1     ? wr1_data :
                                         hit0     ? wr0_data :
                                                    regs_q[addr];
    // A register being written this cycle has its producer retiring now.
    assign rd_busy[k] = addr_nz && busy_q[addr] && !(hit0 || hit1);
`else
    assign rd_data[k*DATA_W +: DATA_W] = addr_nz ? regs_q[addr] : '0;
    assign rd_busy[k] = addr_nz && busy_q[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: a default-parameter instance checked against an
// array-based reference model, plus a small 4-port/16-bit/8-entry instance.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 1 << AW;

  localparam int S_DW = 16;
  localparam int S_AW = 3;
  localparam int S_NR = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en, wr1_en, busy_set_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, busy_set_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [DEPTH-1:0]  busy_vec;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .busy_vec(busy_vec)
  );

  // ---------------- small DUT signals ----------------
  logic [S_NR*S_AW-1:0]  s_rd_addr;
  logic [S_NR*S_DW-1:0]  s_rd_data;
  logic [S_NR-1:0]       s_rd_busy;
  logic                  s_wr0_en, s_wr1_en, s_busy_set_en;
  logic [S_AW-1:0]       s_wr0_addr, s_wr1_addr, s_busy_set_addr;
  logic [S_DW-1:0]       s_wr0_data, s_wr1_data;
  logic [(1<<S_AW)-1:0]  s_busy_vec;

  regfile_mp #(.DATA_W(S_DW), .ADDR_W(S_AW), .NUM_RD(S_NR)) dut_s (
    .clk(clk), .reset(reset),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr0_en(s_wr0_en), .wr0_addr(s_wr0_addr), .wr0_data(s_wr0_data),
    .wr1_en(s_wr1_en), .wr1_addr(s_wr1_addr), .wr1_data(s_wr1_data),
    .busy_set_en(s_busy_set_en), .busy_set_addr(s_busy_set_addr),
    .busy_vec(s_busy_vec)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0]    model_mem [DEPTH];
  logic [DEPTH-1:0] model_busy;
  int total = 0;
  int bad   = 0;

  // Applies the architectural effect of one clock edge given current inputs.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_busy = '0;
    end else begin
      if (wr0_en && wr0_addr != 0) begin
        model_mem[wr0_addr] = wr0_data;
        model_busy[wr0_addr] = 1'b0;
      end
      if (wr1_en && wr1_addr != 0) begin
        model_mem[wr1_addr] = wr1_data;
        model_busy[wr1_addr] = 1'b0;
      end
      if (busy_set_en && busy_set_addr != 0) model_busy[busy_set_addr] = 1'b1;
    end
  endtask

  function automatic logic written_now(input logic [AW-1:0] a);
    return (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
`endif
    return model_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (written_now(a)) return 1'b0;
`endif
    return model_busy[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
    s_wr0_en = 1'b0; s_wr0_addr = '0; s_wr0_data = '0;
    s_wr1_en = 1'b0; s_wr1_addr = '0; s_wr1_data = '0;
    s_busy_set_en = 1'b0; s_busy_set_addr = '0;
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are sampled
  // mid-cycle, well away from the edges.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] got_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    busy_set_en = 1'b1; busy_set_addr = 5'd6;
    tick();
    // Reset with a write and busy_set pending: reset must override both.
    reset = 1'b1;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h12345678;
    tick();
    reset = 1'b0;
    idle();
    set_rd(0, 5'd5); set_rd(1, 5'd6);
    #2;
    total++;
    if (got_data(0) !== 32'h0) begin
      bad++; $display("FAIL reset_r5 got=%h exp=%h", got_data(0), 32'h0);
    end
    total++;
    if (got_data(1) !== 32'h0) begin
      bad++; $display("FAIL reset_r6 got=%h exp=%h", got_data(1), 32'h0);
    end
    total++;
    if (busy_vec !== '0) begin
      bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec);
    end
    total++;
    if (rd_busy !== '0) begin
      bad++; $display("FAIL reset_rd_busy got=%b exp=0", rd_busy);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'h5678;
    busy_set_en = 1'b1; busy_set_addr = 5'd0;
    tick();
    idle();
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    #2;
    total++;
    if (got_data(0) !== 32'h0 || got_data(1) !== 32'h0) begin
      bad++; $display("FAIL zero_data got=%h/%h exp=0", got_data(0), got_data(1));
    end
    total++;
    if (rd_busy !== 2'b00) begin
      bad++; $display("FAIL zero_rd_busy got=%b exp=00", rd_busy);
    end
    total++;
    if (busy_vec[0] !== 1'b0) begin
      bad++; $display("FAIL zero_busy_vec0 got=%b exp=0", busy_vec[0]);
    end
  endtask

  task automatic test_collision();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    tick();
    idle();
    set_rd(0, 5'd7);
    #2;
    total++;
    if (got_data(0) !== 32'h22) begin
      bad++; $display("FAIL collide_r7 got=%h exp=%h", got_data(0), 32'h22);
    end
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'hB;
    tick();
    idle();
    set_rd(0, 5'd3); set_rd(1, 5'd4);
    #2;
    total++;
    if (got_data(0) !== 32'hA || got_data(1) !== 32'hB) begin
      bad++; $display("FAIL separate_r3_r4 got=%h/%h exp=a/b", got_data(0), got_data(1));
    end
  endtask

  task automatic test_scoreboard();
    idle();
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    tick();
    idle();
    set_rd(0, 5'd9); set_rd(1, 5'd10);
    #2;
    total++;
    if (busy_vec[9] !== 1'b1 || rd_busy !== 2'b01) begin
      bad++; $display("FAIL sb_set vec9=%b rd_busy=%b exp=1/01", busy_vec[9], rd_busy);
    end
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h55;
    tick();
    idle();
    #2;
    total++;
    if (busy_vec[9] !== 1'b0 || got_data(0) !== 32'h55) begin
      bad++; $display("FAIL sb_clear vec9=%b data=%h exp=0/55", busy_vec[9], got_data(0));
    end
    busy_set_en = 1'b1; busy_set_addr = 5'd9;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h66;
    tick();
    idle();
    #2;
    total++;
    if (busy_vec[9] !== 1'b1 || got_data(0) !== 32'h66) begin
      bad++; $display("FAIL sb_set_wins vec9=%b data=%h exp=1/66", busy_vec[9], got_data(0));
    end
  endtask

  task automatic test_bypass();
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h1;
    busy_set_en = 1'b1; busy_set_addr = 5'd2;
    tick();
    idle();
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h99;
    set_rd(0, 5'd2); set_rd(1, 5'd2);
    #2;
`ifdef REGFILE_BYPASS_EN
    total++;
    if (got_data(0) !== 32'h99 || got_data(1) !== 32'h99 || rd_busy !== 2'b00) begin
      bad++; $display("FAIL bypass_same_cycle got=%h/%h busy=%b exp=99/99/00",
                      got_data(0), got_data(1), rd_busy);
    end
`else
    total++;
    if (got_data(0) !== 32'h1 || got_data(1) !== 32'h1 || rd_busy !== 2'b11) begin
      bad++; $display("FAIL nobypass_same_cycle got=%h/%h busy=%b exp=1/1/11",
                      got_data(0), got_data(1), rd_busy);
    end
`endif
    tick();
    idle();
    #2;
    total++;
    if (got_data(0) !== 32'h99 || got_data(1) !== 32'h99 || rd_busy !== 2'b00) begin
      bad++; $display("FAIL bypass_next_cycle got=%h/%h busy=%b exp=99/99/00",
                      got_data(0), got_data(1), rd_busy);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      wr0_en = $urandom_range(0, 1) == 1;
      wr0_addr = AW'($urandom_range(0, 9));
      wr0_data = $urandom;
      wr1_en = $urandom_range(0, 1) == 1;
      wr1_addr = AW'($urandom_range(0, 9));
      wr1_data = $urandom;
      busy_set_en = $urandom_range(0, 1) == 1;
      busy_set_addr = AW'($urandom_range(0, 9));
      for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom_range(0, 11)));
      #2;
      for (int k = 0; k < NR; k++) begin
        a = rd_addr[k*AW +: AW];
        total++;
        if (got_data(k) !== exp_data(a)) begin
          bad++; $display("FAIL rand_data n=%0d port=%0d addr=%0d got=%h exp=%h",
                          n, k, a, got_data(k), exp_data(a));
        end
        total++;
        if (rd_busy[k] !== exp_busy(a)) begin
          bad++; $display("FAIL rand_busy n=%0d port=%0d addr=%0d got=%b exp=%b",
                          n, k, a, rd_busy[k], exp_busy(a));
        end
      end
      total++;
      if (busy_vec !== model_busy) begin
        bad++; $display("FAIL rand_busy_vec n=%0d got=%h exp=%h", n, busy_vec, model_busy);
      end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_small_config();
    logic [S_DW-1:0] exp_s [S_NR];
    logic [S_AW-1:0] sel [S_NR];
    idle();
    for (int i = 1; i < 8; i++) begin
      if (i % 2 == 1) begin
        s_wr1_en = 1'b1; s_wr1_addr = S_AW'(i); s_wr1_data = S_DW'(i * 16'h1111);
      end else begin
        s_wr0_en = 1'b1; s_wr0_addr = S_AW'(i); s_wr0_data = S_DW'(i * 16'h1111);
      end
      tick();
      idle();
    end
    s_wr0_en = 1'b1; s_wr0_addr = 3'd0; s_wr0_data = 16'hBEEF;
    tick();
    idle();
    sel[0] = 3'd7; sel[1] = 3'd1; sel[2] = 3'd0; sel[3] = 3'd4;
    exp_s[0] = 16'h7777; exp_s[1] = 16'h1111; exp_s[2] = 16'h0; exp_s[3] = 16'h4444;
    for (int k = 0; k < S_NR; k++) s_rd_addr[k*S_AW +: S_AW] = sel[k];
    #2;
    for (int k = 0; k < S_NR; k++) begin
      total++;
      if (s_rd_data[k*S_DW +: S_DW] !== exp_s[k]) begin
        bad++; $display("FAIL small_port port=%0d addr=%0d got=%h exp=%h",
                        k, sel[k], s_rd_data[k*S_DW +: S_DW], exp_s[k]);
      end
    end
    total++;
    if (s_busy_vec !== 8'h00 || s_rd_busy !== 4'h0) begin
      bad++; $display("FAIL small_busy vec=%h rd_busy=%b exp=0/0", s_busy_vec, s_rd_busy);
    end
  endtask

  // ---------------- sequencer / report ----------------
  initial begin
    reset = 1'b1;
    rd_addr = '0;
    s_rd_addr = '0;
    idle();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
    model_busy = 'x;
    #1;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_zero_reg();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random();
    test_small_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
